// File: rtl/led_arb_pkg.sv
// Shared definitions for the LED write arbiter: FSM encoding, LED target
// addresses and the width of the inter-write gap counter.
package led_arb_pkg;

  // Arbiter FSM encoding.
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    WRITE = 2'b01,
    GAP   = 2'b10
  } arb_state_t;

  // LED register block targets: both low codes select bits 15:0, HI selects 23:16.
  localparam logic [1:0] LED_LO0 = 2'b00;
  localparam logic [1:0] LED_LO1 = 2'b01;
  localparam logic [1:0] LED_HI  = 2'b10;

  // Gap counter width; enough for up to 15 idle cycles between writes.
  localparam int GAP_W = 4;

  // Value loaded into the gap counter on entry to GAP (counts down to 0).
  function automatic logic [GAP_W-1:0] gap_load(input int gap_cycles);
    if (gap_cycles > 0) begin
      return GAP_W'(gap_cycles - 1);
    end
    return '0;
  endfunction

endpackage

// File: rtl/led_arb_rr.sv
// Two-way round-robin grant for the CPU and debug requesters.
// The grant is combinational from the live requests; the last-grant
// pointer only moves when the arbiter actually commits to a write.
module led_arb_rr
  import led_arb_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic cpu_req,
  input  logic dbg_req,
  input  logic take,
  output logic grant_cpu,
  output logic grant_dbg
);

  // High when the CPU was the most recent winner; cleared so the CPU wins the first tie.
  logic last_cpu_reg;

  // Lone requester always wins; on a tie the port not granted last wins.
  always_comb begin
    grant_cpu = cpu_req && (!dbg_req || !last_cpu_reg);
    grant_dbg = dbg_req && !grant_cpu;
  end

  // Record the winner only at the edge where a write is actually started.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      last_cpu_reg <= 1'b0;
    end else if (take && (cpu_req || dbg_req)) begin
      last_cpu_reg <= grant_cpu;
    end
  end

endmodule

// File: rtl/led_write_arbiter.sv
// Arbitrates LED register writes between a CPU port and a debug port.
// A granted request produces a single-cycle write strobe plus ack, followed
// by GAP_CYCLES forced idle cycles during which requests are ignored.
module led_write_arbiter
  import led_arb_pkg::*;
#(
  parameter int GAP_CYCLES = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic [1:0]  cpu_addr,
  input  logic [15:0] cpu_data,
  output logic        cpu_ack,
  input  logic        dbg_req,
  input  logic [1:0]  dbg_addr,
  input  logic [15:0] dbg_data,
  output logic        dbg_ack,
  output logic        led_ctrl,
  output logic        io_write,
  output logic [1:0]  led_addr,
  output logic [15:0] write_data,
  output logic        busy
);

  localparam logic [GAP_W-1:0] GAP_LOAD = gap_load(GAP_CYCLES);
  localparam bit               HAS_GAP  = (GAP_CYCLES > 0);

  arb_state_t       state;
  logic [GAP_W-1:0] gap_cnt;
  logic             grant_cpu;
  logic             grant_dbg;
  logic             take;
  logic [1:0]       win_addr;
  logic [15:0]      win_data;

  // Requests are only considered while idle; this also gates the pointer update.
  assign take = (state == IDLE);

  led_arb_rr u_rr (
    .clock     (clock),
    .reset     (reset),
    .cpu_req   (cpu_req),
    .dbg_req   (dbg_req),
    .take      (take),
    .grant_cpu (grant_cpu),
    .grant_dbg (grant_dbg)
  );

  // Winner's address and data; the address is forwarded untouched, including 2'b11.
  always_comb begin
    win_addr = grant_dbg ? dbg_addr : cpu_addr;
    win_data = grant_dbg ? dbg_data : cpu_data;
  end

  // Busy reflects any non-idle state directly from the state register.
  assign busy = (state != IDLE);

  // Arbiter FSM with registered strobes, acks and forwarded address/data.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      gap_cnt    <= '0;
      led_ctrl   <= 1'b0;
      io_write   <= 1'b0;
      cpu_ack    <= 1'b0;
      dbg_ack    <= 1'b0;
      led_addr   <= LED_LO0;
      write_data <= 16'h0000;
    end else begin
      case (state)
        IDLE: begin
          if (grant_cpu || grant_dbg) begin
            state      <= WRITE;
            led_ctrl   <= 1'b1;
            io_write   <= 1'b1;
            cpu_ack    <= grant_cpu;
            dbg_ack    <= grant_dbg;
            led_addr   <= win_addr;
            write_data <= win_data;
          end
        end
        WRITE: begin
          // Strobe and ack last exactly one cycle; address/data keep their value.
          led_ctrl <= 1'b0;
          io_write <= 1'b0;
          cpu_ack  <= 1'b0;
          dbg_ack  <= 1'b0;
          if (HAS_GAP) begin
            state   <= GAP;
            gap_cnt <= GAP_LOAD;
          end else begin
            state <= IDLE;
          end
        end
        GAP: begin
          // Leave at the edge where the counter already reads zero.
          if (gap_cnt == '0) begin
            state <= IDLE;
          end else begin
            gap_cnt <= gap_cnt - 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          gap_cnt  <= '0;
          led_ctrl <= 1'b0;
          io_write <= 1'b0;
          cpu_ack  <= 1'b0;
          dbg_ack  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_led_write_arbiter.sv
// Scoreboard bench for led_write_arbiter: instance 0 uses GAP_CYCLES=2,
// instance 1 uses GAP_CYCLES=0. A timeline model predicts each write from
// the requests seen at each rising edge; a monitor compares every cycle.
module tb_led_write_arbiter;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset      [2];
  logic        cpu_req    [2];
  logic [1:0]  cpu_addr   [2];
  logic [15:0] cpu_data   [2];
  logic        cpu_ack    [2];
  logic        dbg_req    [2];
  logic [1:0]  dbg_addr   [2];
  logic [15:0] dbg_data   [2];
  logic        dbg_ack    [2];
  logic        led_ctrl   [2];
  logic        io_write   [2];
  logic [1:0]  led_addr   [2];
  logic [15:0] write_data [2];
  logic        busy       [2];

  int n_pass  = 0;
  int n_total = 0;

  bit keep [2];
  bit rnd  [2];

  logic [15:0] wlog_data [2][64];
  bit          wlog_dbg  [2][64];
  int          wlog_edge [2][64];
  int          wlog_n    [2];
  int          cpu_acks  [2];
  int          dbg_acks  [2];
  int          busy_cnt  [2];

  typedef struct {
    bit          dbg;
    logic [1:0]  a;
    logic [15:0] d;
    int          e;
  } exp_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: actual %h required %h", name, act, req);
  endtask

  function automatic logic [31:0] out_vec(input int i);
    return {9'b0, io_write[i], led_ctrl[i], cpu_ack[i], dbg_ack[i], busy[i],
            led_addr[i], write_data[i]};
  endfunction

  for (genvar gi = 0; gi < 2; gi++) begin : g_inst
    localparam int G = (gi == 0) ? 2 : 0;

    led_write_arbiter #(.GAP_CYCLES(G)) u_dut (
      .clock      (clock),
      .reset      (reset[gi]),
      .cpu_req    (cpu_req[gi]),
      .cpu_addr   (cpu_addr[gi]),
      .cpu_data   (cpu_data[gi]),
      .cpu_ack    (cpu_ack[gi]),
      .dbg_req    (dbg_req[gi]),
      .dbg_addr   (dbg_addr[gi]),
      .dbg_data   (dbg_data[gi]),
      .dbg_ack    (dbg_ack[gi]),
      .led_ctrl   (led_ctrl[gi]),
      .io_write   (io_write[gi]),
      .led_addr   (led_addr[gi]),
      .write_data (write_data[gi]),
      .busy       (busy[gi])
    );

    // Model pushes at the rising edge, monitor pops and compares at the falling edge.
    initial begin : p_score
      exp_t        q[$];
      exp_t        e;
      int          edge_n;
      int          free_at;
      bit          last_cpu;
      bit          strobe;
      logic [1:0]  hold_a;
      logic [15:0] hold_d;
      logic [31:0] expv;
      edge_n = 0; free_at = 0; last_cpu = 0; hold_a = '0; hold_d = '0;
      e = '{dbg: 1'b0, a: 2'b00, d: 16'h0, e: 0};
      forever begin
        @(posedge clock);
        edge_n++;
        if (reset[gi]) begin
          q.delete(); free_at = 0; last_cpu = 0; hold_a = '0; hold_d = '0;
        end else if (edge_n >= free_at && (cpu_req[gi] || dbg_req[gi])) begin
          e.dbg = !cpu_req[gi] || (dbg_req[gi] && last_cpu);
          e.a   = e.dbg ? dbg_addr[gi] : cpu_addr[gi];
          e.d   = e.dbg ? dbg_data[gi] : cpu_data[gi];
          e.e   = edge_n;
          q.push_back(e);
          last_cpu = !e.dbg;
          free_at  = edge_n + G + 2;
        end
        @(negedge clock);
        if (io_write[gi] && wlog_n[gi] < 64) begin
          wlog_data[gi][wlog_n[gi]] = write_data[gi];
          wlog_dbg[gi][wlog_n[gi]]  = dbg_ack[gi];
          wlog_edge[gi][wlog_n[gi]] = edge_n;
          wlog_n[gi]++;
        end
        if (cpu_ack[gi]) cpu_acks[gi]++;
        if (dbg_ack[gi]) dbg_acks[gi]++;
        if (busy[gi]) busy_cnt[gi]++;
        if (reset[gi]) begin
          q.delete(); free_at = 0; last_cpu = 0; hold_a = '0; hold_d = '0;
        end else begin
          strobe = (q.size() > 0);
          if (strobe) begin
            e = q.pop_front();
            hold_a = e.a;
            hold_d = e.d;
          end
          expv = {9'b0, strobe, strobe, strobe && !e.dbg, strobe && e.dbg,
                  (edge_n < free_at - 1), hold_a, hold_d};
          check($sformatf("inst%0d_cycle%0d", gi, edge_n), out_vec(gi), expv);
        end
      end
    end
  end

  task automatic clear_stats(input int i);
    wlog_n[i] = 0; cpu_acks[i] = 0; dbg_acks[i] = 0; busy_cnt[i] = 0;
  endtask

  task automatic rand_req(input logic ack, inout logic req, inout logic [1:0] a,
                          inout logic [15:0] d);
    if (ack) begin
      req = ($urandom_range(0, 1) == 1);
      a   = 2'($urandom);
      d   = 16'($urandom);
    end else if (req) begin
      if ($urandom_range(0, 15) == 0) req = 1'b0;
    end else if ($urandom_range(0, 2) == 0) begin
      req = 1'b1;
      a   = 2'($urandom);
      d   = 16'($urandom);
    end
  endtask

  // Advance to just after the falling edge and apply each port's request policy.
  task automatic step();
    @(negedge clock);
    #1;
    for (int i = 0; i < 2; i++) begin
      if (rnd[i]) begin
        rand_req(cpu_ack[i], cpu_req[i], cpu_addr[i], cpu_data[i]);
        rand_req(dbg_ack[i], dbg_req[i], dbg_addr[i], dbg_data[i]);
      end else if (!keep[i]) begin
        if (cpu_ack[i]) cpu_req[i] = 1'b0;
        if (dbg_ack[i]) dbg_req[i] = 1'b0;
      end
    end
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic do_reset(input int i);
    reset[i] = 1'b1;
    run(2);
    reset[i] = 1'b0;
  endtask

  initial begin
    int k;
    for (int i = 0; i < 2; i++) begin
      reset[i] = 1'b1; keep[i] = 0; rnd[i] = 0;
      cpu_req[i] = 0; cpu_addr[i] = '0; cpu_data[i] = '0;
      dbg_req[i] = 0; dbg_addr[i] = '0; dbg_data[i] = '0;
      clear_stats(i);
    end
    run(2);
    for (int i = 0; i < 2; i++) check($sformatf("reset_state%0d", i), out_vec(i), 32'h0);
    reset[0] = 1'b0;
    reset[1] = 1'b0;
    run(3);

    // Single CPU write
    clear_stats(0);
    cpu_addr[0] = 2'b00; cpu_data[0] = 16'hA5A5; cpu_req[0] = 1'b1;
    run(10);
    check("single_count", wlog_n[0], 1);
    check("single_data", wlog_data[0][0], 16'hA5A5);
    check("single_port", wlog_dbg[0][0], 0);
    check("single_ack", cpu_acks[0], 1);
    check("single_busy", busy_cnt[0], 3);

    // Simultaneous requests after reset
    do_reset(0);
    clear_stats(0);
    cpu_addr[0] = 2'b00; cpu_data[0] = 16'h0001; cpu_req[0] = 1'b1;
    dbg_addr[0] = 2'b10; dbg_data[0] = 16'h00FF; dbg_req[0] = 1'b1;
    run(14);
    check("tie_count", wlog_n[0], 2);
    check("tie_first", {wlog_dbg[0][0], wlog_data[0][0]}, {1'b0, 16'h0001});
    check("tie_second", {wlog_dbg[0][1], wlog_data[0][1]}, {1'b1, 16'h00FF});
    check("tie_spacing", wlog_edge[0][1] - wlog_edge[0][0], 4);
    check("tie_acks", {cpu_acks[0][7:0], dbg_acks[0][7:0]}, 16'h0101);

    // Fairness under continuous requests
    do_reset(0);
    clear_stats(0);
    keep[0] = 1;
    cpu_addr[0] = 2'b01; cpu_data[0] = 16'h0C0C; cpu_req[0] = 1'b1;
    dbg_addr[0] = 2'b11; dbg_data[0] = 16'h0D0D; dbg_req[0] = 1'b1;
    for (int t = 0; t < 100 && wlog_n[0] < 8; t++) step();
    cpu_req[0] = 1'b0; dbg_req[0] = 1'b0; keep[0] = 0;
    check("fair_count", wlog_n[0], 8);
    for (int j = 0; j < 8; j++) check($sformatf("fair_order%0d", j), wlog_dbg[0][j], j % 2);
    check("fair_acks", {cpu_acks[0][7:0], dbg_acks[0][7:0]}, 16'h0404);
    run(6);

    // Back-to-back writes with no gap
    clear_stats(1);
    keep[1] = 1; k = 1;
    cpu_addr[1] = 2'b10; cpu_data[1] = 16'h0001; cpu_req[1] = 1'b1;
    for (int t = 0; t < 40 && cpu_req[1]; t++) begin
      step();
      if (cpu_ack[1]) begin
        if (k == 3) cpu_req[1] = 1'b0;
        else begin k++; cpu_data[1] = 16'(k); end
      end
    end
    keep[1] = 0; cpu_req[1] = 1'b0;
    run(4);
    check("nogap_count", wlog_n[1], 3);
    for (int j = 0; j < 3; j++) check($sformatf("nogap_data%0d", j), wlog_data[1][j], j + 1);
    check("nogap_spacing1", wlog_edge[1][1] - wlog_edge[1][0], 2);
    check("nogap_spacing2", wlog_edge[1][2] - wlog_edge[1][1], 2);

    // Reset during the strobe cycle
    clear_stats(0);
    dbg_addr[0] = 2'b01; dbg_data[0] = 16'h1234; dbg_req[0] = 1'b1;
    for (int t = 0; t < 20; t++) begin
      @(posedge clock);
      #1;
      if (io_write[0]) break;
    end
    check("abort_strobe", {io_write[0], dbg_ack[0]}, 2'b11);
    reset[0] = 1'b1;
    #1;
    check("abort_drop", out_vec(0), 32'h0);
    dbg_req[0] = 1'b0;
    run(2);
    reset[0] = 1'b0;
    check("abort_no_ack", {wlog_n[0][7:0], dbg_acks[0][7:0]}, 16'h0000);
    cpu_addr[0] = 2'b00; cpu_data[0] = 16'h5555; cpu_req[0] = 1'b1;
    run(8);
    check("abort_next", {wlog_n[0][7:0], wlog_data[0][0]}, {8'd1, 16'h5555});

    // Debug pulse confined to the gap
    clear_stats(0);
    cpu_addr[0] = 2'b00; cpu_data[0] = 16'h7777; cpu_req[0] = 1'b1;
    for (int t = 0; t < 20; t++) begin
      step();
      if (cpu_ack[0]) break;
    end
    step();
    dbg_addr[0] = 2'b10; dbg_data[0] = 16'hBEEF; dbg_req[0] = 1'b1;
    step();
    dbg_req[0] = 1'b0;
    run(8);
    check("gap_pulse", {wlog_n[0][7:0], dbg_acks[0][7:0]}, 16'h0100);

    // Randomized traffic on both instances
    rnd[0] = 1; rnd[1] = 1;
    run(3000);
    rnd[0] = 0; rnd[1] = 0;
    for (int i = 0; i < 2; i++) begin
      cpu_req[i] = 1'b0;
      dbg_req[i] = 1'b0;
    end
    run(10);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
